// File: rtl/uart_data_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, baud_set codes and divisors,
// default inter-byte timeout. Reused by the transmit side.
package uart_data_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } rx_state_t;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;
  localparam logic [2:0] BAUD_230400 = 3'd5;
  localparam logic [2:0] BAUD_460800 = 3'd6;
  localparam logic [2:0] BAUD_921600 = 3'd7;

  localparam int CLK_FREQ_HZ            = 50_000_000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 104166;

  // Clock cycles per serial bit at a 50 MHz system clock.
  function automatic logic [12:0] baud_div(input logic [2:0] code);
    logic [12:0] div;
    case (code)
      BAUD_9600:   div = 13'd5208;
      BAUD_19200:  div = 13'd2604;
      BAUD_38400:  div = 13'd1302;
      BAUD_57600:  div = 13'd868;
      BAUD_115200: div = 13'd434;
      BAUD_230400: div = 13'd217;
      BAUD_460800: div = 13'd108;
      default:     div = 13'd54;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_data_rx_byte_rx.sv
// uart_byte_rx: single 8N1 byte receiver with input synchroniser and mid-bit sampling.
// A bad stop bit drops the byte silently (no rx_done).
module uart_byte_rx
  import uart_data_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done
);

  logic [2:0]  sync;
  logic        active;
  logic [12:0] baud_cnt;
  logic [12:0] div;
  logic [3:0]  bit_idx;
  logic [7:0]  shifter;

  assign div = baud_div(baud_set);

  // sync[1] is the synchronised line, sync[2] its previous value for start-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync      <= 3'b111;
      active    <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
      data_byte <= '0;
      rx_done   <= 1'b0;
    end else begin
      sync    <= {sync[1:0], uart_rx};
      rx_done <= 1'b0;
      if (!active) begin
        if (sync[2] && !sync[1]) begin
          active   <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      end else begin
        if (baud_cnt == div - 13'd1) begin
          baud_cnt <= '0;
          bit_idx  <= bit_idx + 4'd1;
        end else begin
          baud_cnt <= baud_cnt + 13'd1;
        end
        if (baud_cnt == (div >> 1)) begin
          case (bit_idx)
            4'd0: if (sync[1]) active <= 1'b0;
            4'd9: begin
              active <= 1'b0;
              if (sync[1]) begin
                data_byte <= shifter;
                rx_done   <= 1'b1;
              end
            end
            default: shifter <= {sync[1], shifter[7:1]};
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/uart_data_rx.sv
// uart_data_rx: assembles DATA_WIDTH/8 received UART bytes into one word with rx_done pulse.
// Optional inter-byte timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_data_rx
  import uart_data_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  uart_rx,
  input  logic [2:0]            baud_set,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  rx_done,
  output logic                  rx_busy,
  output logic                  timeout_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sreg;
  logic [7:0]            byte_data;
  logic                  byte_done;
  logic                  timeout_hit;

  uart_byte_rx u_byte_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data_byte (byte_data),
    .rx_done   (byte_done)
  );

  // The wider concatenation keeps W==8 free of zero-width slices.
  function automatic logic [DATA_WIDTH-1:0] push_byte(input logic [DATA_WIDTH-1:0] s,
                                                      input logic [7:0] b);
    logic [DATA_WIDTH+7:0] cat;
    if (MSB_FIRST != 0) begin
      cat = {s, b};
      return cat[DATA_WIDTH-1:0];
    end else begin
      cat = {b, s};
      return cat[DATA_WIDTH+7:8];
    end
  endfunction

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (byte_done || state != ST_COLLECT) begin
      idle_cnt <= '0;
    end else if (idle_cnt != {TW{1'b1}}) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_COLLECT) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte arriving in the same cycle as the timeout terminal count takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sreg        <= '0;
      data        <= '0;
      rx_done     <= 1'b0;
      rx_busy     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_done     <= 1'b0;
      timeout_err <= 1'b0;
      if (byte_done) sreg <= push_byte(sreg, byte_data);
      case (state)
        ST_IDLE: begin
          if (byte_done) begin
            cnt <= CW'(1);
            if (NBYTES == 1) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_COLLECT;
              rx_busy <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (byte_done) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              state   <= ST_DONE;
              rx_busy <= 1'b0;
            end
          end else if (timeout_hit) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rx_busy     <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        ST_DONE: begin
          data    <= sreg;
          rx_done <= 1'b1;
          if (byte_done) begin
            cnt <= CW'(1);
            if (NBYTES == 1) begin
              state <= ST_DONE;
            end else begin
              state   <= ST_COLLECT;
              rx_busy <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          cnt     <= '0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_data_rx.sv
// Directed bench for uart_data_rx: four instances (32/MSB, 32/LSB, 8, 24) fed by a
// bit-banged 921600-baud serial line; timeout expectations follow UART_RX_TIMEOUT_EN.
module tb_uart_data_rx;

  localparam int BIT_CLKS = 54;
  localparam int TMO      = 3000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] baud_set;
  logic [3:0] rx_line;

  logic [31:0] d32m, d32l;
  logic [7:0]  d8;
  logic [23:0] d24;
  logic [3:0]  done_v, busy_v, tmo_v;
  logic [31:0] data_v [4];

  int tests_run = 0;
  int failures  = 0;
  int done_cnt [4] = '{default: 0};
  int tmo_cnt  [4] = '{default: 0};
  logic [31:0] hist [4][16];
  int busy_run = 0;
  int busy_max = 0;
  int base, tbase;
  logic found;

  always #10 clk = ~clk;

  uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)) u_m32 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_line[0]), .baud_set(baud_set),
    .data(d32m), .rx_done(done_v[0]), .rx_busy(busy_v[0]), .timeout_err(tmo_v[0]));

  uart_data_rx #(.DATA_WIDTH(32), .MSB_FIRST(0), .TIMEOUT_CYCLES(TMO)) u_l32 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_line[1]), .baud_set(baud_set),
    .data(d32l), .rx_done(done_v[1]), .rx_busy(busy_v[1]), .timeout_err(tmo_v[1]));

  uart_data_rx #(.DATA_WIDTH(8), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)) u_w8 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_line[2]), .baud_set(baud_set),
    .data(d8), .rx_done(done_v[2]), .rx_busy(busy_v[2]), .timeout_err(tmo_v[2]));

  uart_data_rx #(.DATA_WIDTH(24), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)) u_w24 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_line[3]), .baud_set(baud_set),
    .data(d24), .rx_done(done_v[3]), .rx_busy(busy_v[3]), .timeout_err(tmo_v[3]));

  assign data_v[0] = d32m;
  assign data_v[1] = d32l;
  assign data_v[2] = {24'h0, d8};
  assign data_v[3] = {8'h0, d24};

  // Record every completed word and timeout pulse per instance.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        hist[i][done_cnt[i] % 16] <= data_v[i];
        done_cnt[i] <= done_cnt[i] + 1;
      end
      if (tmo_v[i]) tmo_cnt[i] <= tmo_cnt[i] + 1;
    end
    if (busy_v[2]) begin
      busy_run <= busy_run + 1;
      if (busy_run + 1 > busy_max) busy_max <= busy_run + 1;
    end else begin
      busy_run <= 0;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_line[idx] = frame[k];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [31:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) send_byte(idx, w[8*k +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    baud_set = 3'd7;
    rx_line  = 4'hF;
    idle(5);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("reset_data%0d", i), data_v[i], 32'h0);
      check_output($sformatf("reset_flags%0d", i), {29'h0, done_v[i], busy_v[i], tmo_v[i]}, 32'h0);
    end
    reset_n = 1'b1;
    idle(5);

    // 32-bit, first byte lands in the top byte
    base = done_cnt[0];
    send_byte(0, 8'h12);
    send_byte(0, 8'h34);
    check_output("m32_busy_mid", {31'h0, busy_v[0]}, 32'h1);
    send_byte(0, 8'h56);
    send_byte(0, 8'h78);
    idle(10);
    check_output("m32_done_count", done_cnt[0] - base, 32'd1);
    check_output("m32_word", hist[0][base % 16], 32'h12345678);
    check_output("m32_data_held", d32m, 32'h12345678);
    check_output("m32_busy_after", {31'h0, busy_v[0]}, 32'h0);

    // 32-bit, first byte lands in the bottom byte
    base = done_cnt[1];
    apply_stimulus(1, 32'h78563412, 4);
    idle(10);
    check_output("l32_done_count", done_cnt[1] - base, 32'd1);
    check_output("l32_word", d32l, 32'h12345678);
    apply_stimulus(1, 32'h12345678, 4);
    idle(10);
    check_output("l32_swapped_word", d32l, 32'h78563412);
    check_output("l32_done_count2", done_cnt[1] - base, 32'd2);

    // 8-bit: rx_done exactly two cycles after the byte receiver's pulse
    base  = done_cnt[2];
    found = 1'b0;
    fork
      send_byte(2, 8'hA5);
      begin
        for (int k = 0; k < 700; k++) begin
          @(negedge clk);
          if (u_w8.u_byte_rx.rx_done) begin
            found = 1'b1;
            break;
          end
        end
        check_output("w8_byte_done_seen", {31'h0, found}, 32'h1);
        @(negedge clk);
        check_output("w8_done_lat1", {31'h0, done_v[2]}, 32'h0);
        @(negedge clk);
        check_output("w8_done_lat2", {31'h0, done_v[2]}, 32'h1);
        check_output("w8_data_at_done", data_v[2], 32'hA5);
        @(negedge clk);
        check_output("w8_done_pulse_end", {31'h0, done_v[2]}, 32'h0);
      end
    join
    idle(10);
    check_output("w8_done_count", done_cnt[2] - base, 32'd1);
    check_output("w8_busy_max", busy_max, 32'd0);

    // 24-bit: partial word followed by a long idle gap
    base  = done_cnt[3];
    tbase = tmo_cnt[3];
    send_byte(3, 8'hAA);
    send_byte(3, 8'hBB);
    idle(TMO + 500);
    check_output("w24_no_done_gap", done_cnt[3] - base, 32'd0);
`ifdef UART_RX_TIMEOUT_EN
    check_output("w24_timeout_count", tmo_cnt[3] - tbase, 32'd1);
    check_output("w24_busy_after_tmo", {31'h0, busy_v[3]}, 32'h0);
    apply_stimulus(3, 32'h00C0FFEE, 3);
    idle(10);
    check_output("w24_done_count", done_cnt[3] - base, 32'd1);
    check_output("w24_word", d24, 32'h00C0FFEE);
    check_output("w24_timeout_once", tmo_cnt[3] - tbase, 32'd1);
`else
    check_output("w24_no_timeout", tmo_cnt[3] - tbase, 32'd0);
    check_output("w24_busy_waits", {31'h0, busy_v[3]}, 32'h1);
    send_byte(3, 8'hC0);
    idle(10);
    check_output("w24_done_count", done_cnt[3] - base, 32'd1);
    check_output("w24_word", d24, 32'h00AABBC0);
    check_output("w24_busy_after", {31'h0, busy_v[3]}, 32'h0);
`endif

    // reset in the middle of a word
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    check_output("rst_busy_before", {31'h0, busy_v[0]}, 32'h1);
    reset_n = 1'b0;
    idle(3);
    check_output("rst_data", d32m, 32'h0);
    check_output("rst_flags", {29'h0, done_v[0], busy_v[0], tmo_v[0]}, 32'h0);
    reset_n = 1'b1;
    idle(5);
    base = done_cnt[0];
    apply_stimulus(0, 32'hCAFEF00D, 4);
    idle(10);
    check_output("rst_next_count", done_cnt[0] - base, 32'd1);
    check_output("rst_next_word", d32m, 32'hCAFEF00D);

    // back-to-back words with no gap
    base = done_cnt[0];
    apply_stimulus(0, 32'hDEADBEEF, 4);
    apply_stimulus(0, 32'h00000001, 4);
    idle(10);
    check_output("b2b_done_count", done_cnt[0] - base, 32'd2);
    check_output("b2b_word0", hist[0][base % 16], 32'hDEADBEEF);
    check_output("b2b_word1", hist[0][(base + 1) % 16], 32'h00000001);
    check_output("b2b_data_held", d32m, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
